// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: geometry, key map and
// the enums used by the scan accumulator and the debounce state machine.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  // Key map indexed by {row[1:0], col[1:0]}; element [0] is (row0, col0).
  // Row 3 holds '*'=E, '0', '#'=F, 'D'.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } scan_res_e;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } db_state_e;

  // Hex code for the key at matrix position {row, col}.
  function automatic logic [3:0] key_lookup(input logic [3:0] pos);
    return KEY_MAP[pos];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to all ones so idle (pulled-up) inputs
// read as inactive while reset is applied.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 keypad scanner and encoder. Drives one active-low column at a time,
// collects the synchronized rows over a full four-column scan, debounces
// the scan result and emits a hex key code with a one-cycle valid pulse.
//
// state    | meaning
// RELEASED | no debounced key down, key_held=0
// PRESSED  | a debounced single key is down, key_held=1
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_SAT   = DB_W'(DEBOUNCE_SCANS);

  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q;
  logic             div_last;
  logic             scan_end;

  // Per-column and whole-scan accumulation.
  logic [1:0]       col_cnt;
  logic [1:0]       col_row;
  logic [1:0]       acc_cnt_q;
  logic [3:0]       acc_key_q;
  logic [2:0]       sum_cnt;
  logic [1:0]       merged_cnt;
  logic [3:0]       merged_key;
  scan_res_e        scan_res;

  // Debounce bookkeeping.
  scan_res_e        cand_res_q;
  logic [3:0]       cand_key_q;
  logic [DB_W-1:0]  stable_q;
  logic [DB_W-1:0]  stable_d;
  logic             same_res;

  db_state_e        state_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_held_q;
  logic [3:0]       scan_code;

  sync_2ff #(.WIDTH(NUM_ROWS)) u_row_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d_i   (row_in),
    .q_o   (row_sync)
  );

  assign div_last = (div_q == DIV_LAST);
  assign scan_end = div_last && (col_q == 2'd3);
  assign col_out  = ~(4'b0001 << col_q);

  // Column dwell divider and column index.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q <= '0;
      col_q <= 2'd0;
    end else if (div_last) begin
      div_q <= '0;
      col_q <= col_q + 2'd1;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Count low rows in the driven column (saturating at 2) and note which row.
  always_comb begin
    col_cnt = 2'd0;
    col_row = 2'd0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!row_sync[r]) begin
        if (col_cnt != 2'd2) col_cnt = col_cnt + 2'd1;
        col_row = 2'(r);
      end
    end
  end

  // Fold the current column into the running scan result.
  always_comb begin
    sum_cnt    = {1'b0, acc_cnt_q} + {1'b0, col_cnt};
    merged_cnt = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    merged_key = (acc_cnt_q != 2'd0) ? acc_key_q : {col_row, col_q};
    case (merged_cnt)
      2'd0:    scan_res = NONE;
      2'd1:    scan_res = SINGLE;
      default: scan_res = MULTI;
    endcase
  end

  // Accumulate over columns 0..3, restart after the column-3 sample.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_cnt_q <= 2'd0;
      acc_key_q <= 4'd0;
    end else if (div_last) begin
      if (col_q == 2'd3) begin
        acc_cnt_q <= 2'd0;
        acc_key_q <= 4'd0;
      end else begin
        acc_cnt_q <= merged_cnt;
        acc_key_q <= merged_key;
      end
    end
  end

  // Stable-scan count for the result completing this cycle.
  always_comb begin
    same_res = (scan_res == cand_res_q) &&
               ((scan_res != SINGLE) || (merged_key == cand_key_q));
    if (scan_res == MULTI) begin
      stable_d = '0;
    end else if (same_res) begin
      stable_d = (stable_q == DB_SAT) ? stable_q : stable_q + DB_W'(1);
    end else begin
      stable_d = DB_W'(1);
    end
  end

  assign scan_code = key_lookup(merged_key);

  // Candidate, stable counter and press/release state machine with registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cand_res_q  <= NONE;
      cand_key_q  <= 4'd0;
      stable_q    <= '0;
      state_q     <= RELEASED;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (scan_end) begin
        cand_res_q <= scan_res;
        cand_key_q <= merged_key;
        stable_q   <= stable_d;
        case (state_q)
          RELEASED: begin
            if ((scan_res == SINGLE) && (stable_d == DB_SAT)) begin
              state_q     <= PRESSED;
              key_code_q  <= scan_code;
              key_valid_q <= 1'b1;
              key_held_q  <= 1'b1;
            end
          end
          PRESSED: begin
            if ((scan_res == SINGLE) && (stable_d == DB_SAT) &&
                (scan_code != key_code_q)) begin
              key_code_q  <= scan_code;
              key_valid_q <= 1'b1;
            end else if ((scan_res == NONE) && (stable_d == DB_SAT)) begin
              state_q    <= RELEASED;
              key_held_q <= 1'b0;
            end
          end
          default: begin
            state_q    <= RELEASED;
            key_held_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-cycle scan).
// A keypad model pulls rows low for pressed keys in the driven column;
// expected key codes are queued when a press is applied and popped on
// each key_valid pulse.
module tb_keypad_encoder;

  localparam int SCAN = 16;

  logic       clk;
  logic       resetn;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;   // index {row, col}
  logic [3:0]  exp_q[$];
  int          vectors;
  int          miscompares;
  int          pulse_cnt;
  int          last_pulse_cyc;
  int          cyc;
  logic        prev_valid;

  keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Physical keypad: a pressed key shorts its row to the driven column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // Scoreboard: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse got code=%h, expected no pulse", key_code);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (key_code !== e) begin
          miscompares++;
          $display("FAIL pulse_code got=%h expected=%h", key_code, e);
        end
      end
      vectors++;
      if (prev_valid === 1'b1) begin
        miscompares++;
        $display("FAIL valid_width got two consecutive cycles, expected one");
      end
    end
    prev_valid = key_valid;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int r, input int c, input logic [3:0] code, input bit expect_pulse);
    pressed[r*4+c] = 1'b1;
    if (expect_pulse) exp_q.push_back(code);
  endtask

  task automatic release_all();
    pressed = '0;
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing_pulse got %0d outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    wait_cyc(10);
    @(negedge clk); #2 resetn = 1'b0; #1;
    vectors += 4;
    if (col_out !== 4'b1110) begin miscompares++; $display("FAIL rst_col got=%b expected=1110", col_out); end
    if (key_code !== 4'h0)   begin miscompares++; $display("FAIL rst_code got=%h expected=0", key_code); end
    if (key_valid !== 1'b0)  begin miscompares++; $display("FAIL rst_valid got=%b expected=0", key_valid); end
    if (key_held !== 1'b0)   begin miscompares++; $display("FAIL rst_held got=%b expected=0", key_held); end
    @(negedge clk); resetn = 1'b1;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      if ((k % 4) == 1) begin
        exp_col = ~(4'b0001 << (k / 4));
        vectors++;
        if (col_out !== exp_col) begin
          miscompares++;
          $display("FAIL col_step k=%0d got=%b expected=%b", k, col_out, exp_col);
        end
      end
    end
  endtask

  task automatic test_single_press();
    int p0, press_cyc;
    p0 = pulse_cnt;
    press_cyc = cyc;
    press(1, 2, 4'h6, 1'b1);
    wait_cyc(10 * SCAN);
    check_drained("press6");
    vectors += 3;
    if (pulse_cnt - p0 !== 1) begin miscompares++; $display("FAIL press6_count got=%0d expected=1", pulse_cnt - p0); end
    if ((last_pulse_cyc - press_cyc) > 4*SCAN + 2) begin
      miscompares++; $display("FAIL press6_latency got=%0d expected<=%0d", last_pulse_cyc - press_cyc, 4*SCAN+2);
    end
    if (key_held !== 1'b1) begin miscompares++; $display("FAIL press6_held got=%b expected=1", key_held); end
    release_all();
    wait_cyc(5 * SCAN);
    vectors += 2;
    if (key_held !== 1'b0) begin miscompares++; $display("FAIL rel6_held got=%b expected=0", key_held); end
    if (key_code !== 4'h6) begin miscompares++; $display("FAIL rel6_code got=%h expected=6", key_code); end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) begin
      pressed[2*4+1] = 1'b1;
      wait_cyc(SCAN);
      pressed[2*4+1] = 1'b0;
      wait_cyc(SCAN);
    end
    vectors++;
    if (pulse_cnt !== p0) begin miscompares++; $display("FAIL bounce_pulses got=%0d expected=0", pulse_cnt - p0); end
    press(2, 1, 4'h8, 1'b1);
    wait_cyc(6 * SCAN);
    check_drained("bounce8");
    vectors++;
    if (key_held !== 1'b1) begin miscompares++; $display("FAIL bounce8_held got=%b expected=1", key_held); end
  endtask

  task automatic test_release_then_star();
    release_all();
    wait_cyc(30);
    vectors++;
    if (key_held !== 1'b1) begin miscompares++; $display("FAIL early_release_held got=%b expected=1", key_held); end
    wait_cyc(40);
    vectors += 2;
    if (key_held !== 1'b0) begin miscompares++; $display("FAIL release8_held got=%b expected=0", key_held); end
    if (key_code !== 4'h8) begin miscompares++; $display("FAIL release8_code got=%h expected=8", key_code); end
    press(3, 0, 4'hE, 1'b1);
    wait_cyc(6 * SCAN);
    check_drained("star");
    vectors++;
    if (key_code !== 4'hE) begin miscompares++; $display("FAIL star_code got=%h expected=E", key_code); end
  endtask

  task automatic test_multi();
    int p0;
    release_all();
    wait_cyc(6 * SCAN);
    p0 = pulse_cnt;
    press(1, 1, 4'h5, 1'b0);
    press(2, 2, 4'h9, 1'b0);
    wait_cyc(10 * SCAN);
    vectors += 2;
    if (pulse_cnt !== p0)  begin miscompares++; $display("FAIL multi_pulses got=%0d expected=0", pulse_cnt - p0); end
    if (key_held !== 1'b0) begin miscompares++; $display("FAIL multi_held got=%b expected=0", key_held); end
    pressed[2*4+2] = 1'b0;
    exp_q.push_back(4'h5);
    wait_cyc(6 * SCAN);
    check_drained("multi5");
    vectors++;
    if (key_code !== 4'h5) begin miscompares++; $display("FAIL multi5_code got=%h expected=5", key_code); end
  endtask

  task automatic test_change_and_reset();
    int dips;
    release_all();
    wait_cyc(6 * SCAN);
    press(0, 3, 4'hA, 1'b1);
    wait_cyc(6 * SCAN);
    check_drained("keyA");
    pressed[0*4+3] = 1'b0;
    press(3, 3, 4'hD, 1'b1);
    dips = 0;
    for (int i = 0; i < 6 * SCAN; i++) begin
      @(negedge clk);
      if (key_held !== 1'b1) dips++;
    end
    check_drained("keyD");
    vectors += 2;
    if (dips !== 0)        begin miscompares++; $display("FAIL change_held_dips got=%0d expected=0", dips); end
    if (key_code !== 4'hD) begin miscompares++; $display("FAIL change_code got=%h expected=D", key_code); end
    @(negedge clk); #2 resetn = 1'b0; #1;
    vectors += 4;
    if (col_out !== 4'b1110) begin miscompares++; $display("FAIL rst2_col got=%b expected=1110", col_out); end
    if (key_code !== 4'h0)   begin miscompares++; $display("FAIL rst2_code got=%h expected=0", key_code); end
    if (key_valid !== 1'b0)  begin miscompares++; $display("FAIL rst2_valid got=%b expected=0", key_valid); end
    if (key_held !== 1'b0)   begin miscompares++; $display("FAIL rst2_held got=%b expected=0", key_held); end
    wait_cyc(3);
    resetn = 1'b1;
    exp_q.push_back(4'hD);
    wait_cyc(7 * SCAN);
    check_drained("rekeyD");
    vectors += 2;
    if (key_held !== 1'b1) begin miscompares++; $display("FAIL rekeyD_held got=%b expected=1", key_held); end
    if (key_code !== 4'hD) begin miscompares++; $display("FAIL rekeyD_code got=%h expected=D", key_code); end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    pulse_cnt      = 0;
    last_pulse_cyc = 0;
    cyc            = 0;
    prev_valid     = 1'b0;
    pressed        = '0;
    resetn         = 1'b0;
    wait_cyc(3);
    resetn = 1'b1;
    test_reset();
    test_single_press();
    test_bounce();
    test_release_then_star();
    test_multi();
    test_change_and_reset();
    release_all();
    wait_cyc(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
